// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits LSB first, parity, one or two stop bits.
// The received byte is held on a valid/ack handshake with parity, framing and overrun status.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | qualifying the start bit at its mid-point
// DATA   | sampling 8 data bits, one per bit period
// PARITY | sampling the parity bit
// STOP1  | sampling the first stop bit (delivers if single stop)
// STOP2  | sampling the second stop bit, then delivers
// BREAK  | stop bit was low; waiting for the line to return high
module uart_rx #(
    parameter int BAUD_DIVISOR = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       two_stop,
    input  logic       odd_parity,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int          HALF    = BAUD_DIVISOR / 2;
    localparam logic [13:0] HALF_M1 = 14'(HALF - 1);
    localparam logic [13:0] FULL_M1 = 14'(BAUD_DIVISOR - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;
    localparam logic [2:0] S_BREAK  = 3'd6;

    logic        rx_meta_q, rx_s_q;
    logic [2:0]  state_q, state_d;
    logic [13:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        two_stop_l_q, two_stop_l_d;
    logic        odd_l_q, odd_l_d;
    logic        par_bad_q, par_bad_d;
    logic        stop_bad_q, stop_bad_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        parity_err_q, parity_err_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        deliver;
    logic        deliver_ferr;
    logic        baud_tick;

    assign baud_tick = (baud_cnt_q == FULL_M1);

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        two_stop_l_d = two_stop_l_q;
        odd_l_d      = odd_l_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        deliver      = 1'b0;
        deliver_ferr = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                if (!rx_s_q) begin
                    two_stop_l_d = two_stop;
                    odd_l_d      = odd_parity;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (baud_cnt_q == HALF_M1) begin
                    baud_cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 14'd1;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = S_PARITY;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 14'd1;
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    par_bad_d  = (^shift_q) ^ rx_s_q ^ odd_l_q;
                    stop_bad_d = 1'b0;
                    state_d    = S_STOP1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 14'd1;
                end
            end
            S_STOP1: begin
                if (baud_tick) begin
                    baud_cnt_d = '0;
                    if (two_stop_l_q) begin
                        stop_bad_d = !rx_s_q;
                        state_d    = S_STOP2;
                    end else begin
                        deliver      = 1'b1;
                        deliver_ferr = !rx_s_q;
                        state_d      = rx_s_q ? S_IDLE : S_BREAK;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 14'd1;
                end
            end
            S_STOP2: begin
                if (baud_tick) begin
                    baud_cnt_d   = '0;
                    deliver      = 1'b1;
                    deliver_ferr = stop_bad_q | !rx_s_q;
                    state_d      = rx_s_q ? S_IDLE : S_BREAK;
                end else begin
                    baud_cnt_d = baud_cnt_q + 14'd1;
                end
            end
            S_BREAK: begin
                baud_cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // An ack on the delivery edge frees the holding register, so the new frame is taken.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        if (rx_valid_q && rx_ack) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                parity_err_d = par_bad_q;
                frame_err_d  = deliver_ferr;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            two_stop_l_q <= 1'b0;
            odd_l_q      <= 1'b0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_in;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            two_stop_l_q <= two_stop_l_d;
            odd_l_q      <= odd_l_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the team's UART transmitter. It deserializes one 8-bit frame per transfer from `rx_in`: one start bit, 8 data bits LSB first, one parity bit, then one or two stop bits. The received byte is presented on a valid/ack handshake, with parity, framing and overrun status. Line format and bit rate are the same as the transmitter's, so a loopback of `Tx_out` to `rx_in` returns the transmitted byte.

## Interface
Parameters:
- `BAUD_DIVISOR`, default 868: clk cycles per bit. Legal range is 4..16383. `HALF = BAUD_DIVISOR/2`, rounded down.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset: asynchronous, active-low
- `rx_in`  in  1  serial line, asynchronous to `clk`, idle high
- `two_stop`  in  1  1 = expect two stop bits; latched at start-bit detection
- `odd_parity`  in  1  1 = odd parity, 0 = even; latched at start-bit detection
- `rx_ack`  in  1  consumer accepts `rx_data`; only meaningful while `rx_valid`=1
- `rx_data`  out  8  received byte
- `rx_valid`  out  1  `rx_data` and the error flags are valid; held until acked
- `parity_err`  out  1  parity mismatch for the byte in `rx_data`
- `frame_err`  out  1  a stop bit was sampled 0 for the byte in `rx_data`
- `overrun_err`  out  1  one-cycle pulse: a completed frame was dropped
- `busy`  out  1  1 in any state other than IDLE

## Operation
- Synchronizer: `rx_in` passes through 2 flops (reset value 1). All logic uses the synchronized signal `rx_s`.
- Datapath:
  - 14-bit `baud_cnt`
  - 4-bit `bit_cnt`
  - 8-bit shift register, filled from the MSB end
  - a latched copy of `two_stop`/`odd_parity`
- FSM states:
  - IDLE: `baud_cnt`=0. If `rx_s`=0, latch config and go to START.
  - START: `baud_cnt` increments. At `baud_cnt`==HALF-1, sample `rx_s`:
    - 1: false start, go to IDLE.
    - 0: clear `baud_cnt`, set `bit_cnt`=0, go to DATA.
  - DATA: sample at `baud_cnt`==BAUD_DIVISOR-1, then clear the counter. Shift the sample in. After the 8th sample (`bit_cnt`==7), go to PARITY.
  - PARITY: sample at `baud_cnt`==BAUD_DIVISOR-1. Error if (XOR of data bits) ^ sample ^ `odd_parity_latched` = 1. Go to STOP1.
  - STOP1: sample at BAUD_DIVISOR-1. A 0 sets the frame error.
    - If `two_stop_latched`: go to STOP2.
    - Otherwise: DELIVER.
  - STOP2: sample at BAUD_DIVISOR-1. A 0 sets the frame error. DELIVER.
  - DELIVER (performed on the final stop-sample cycle, not a separate state):
    - Result registers update at that edge.
    - Next state is IDLE if the final stop sample was 1.
    - Next state is BREAK if it was 0.
  - BREAK: wait until `rx_s`=1, then go to IDLE. A low line is never re-detected as a start bit.
- Handshake:
  - `rx_valid` is set on DELIVER and cleared on the edge where `rx_valid`&`rx_ack`.
  - `rx_data`, `parity_err` and `frame_err` are stable while `rx_valid`=1.
- Overrun:
  - DELIVER with `rx_valid`=1 and `rx_ack`=0: the new frame is discarded, the old data is kept, and `overrun_err` pulses one cycle.
  - DELIVER with `rx_valid`=1 and `rx_ack`=1 in the same cycle: the new frame is loaded, `rx_valid` stays 1, and there is no overrun.
- Reset, including mid-frame: state IDLE, all counters 0, `rx_data`=0x00, every output flag 0, synchronizer flops 1.
- Config inputs may change at any time. Only the values latched at start detection affect the current frame.

## Timing
- Let edge E be the first clk edge at which `rx_s`=0 in IDLE (2-3 cycles after the `rx_in` fall).
- Start-bit mid-sample: E+HALF.
- Data bit k (k = 0..7) sampled at E+HALF+(k+1)·BAUD_DIVISOR.
- Parity sampled at +9·BAUD_DIVISOR.
- STOP1 sampled at +10·BAUD_DIVISOR; STOP2 (two-stop only) at +11·BAUD_DIVISOR.
- `rx_valid` rises the cycle after the final stop sample.
- Back-to-back frames: the receiver is in IDLE during the second half of the last stop bit, so no start edge is missed.
- `rx_ack` is combinationally ignored when `rx_valid`=0.

## Test plan
All scenarios use BAUD_DIVISOR=16.
- Clean frame: 0xA5 with even parity (p=0), 1 stop -> `rx_data`=0xA5, `rx_valid`=1, both error flags 0; `rx_valid` rises 10·16+8 cycles after E, plus 1.
- Odd parity / two stop: 0x3C (p=1), 2 stop, pulse `rx_ack` -> 0x3C with no errors; `rx_valid` drops the cycle after the ack; timing includes the STOP2 sample.
- Errors:
  - 0x81 sent with a wrong parity bit -> `parity_err`=1.
  - Frame with stop=0 and the line then held low for 40 cycles -> `frame_err`=1, FSM stays in BREAK, no new frame until the line goes high.
- Glitch: 5-cycle low pulse on an idle line -> false start, returns to IDLE, no `rx_valid`.
- Overrun: two frames 0x11 then 0x22 with no ack -> `rx_data` stays 0x11, `overrun_err` pulses once. Repeat with `rx_ack` asserted on the DELIVER cycle -> `rx_data`=0x22, `rx_valid` stays high.
- Reset mid-frame, then loopback: `rst_n` low during DATA -> all outputs 0, state IDLE. After release, the next frame is received correctly. Loopback from the transmitter on 0x00, 0xFF and 0x5A with all four parity/stop combinations -> bytes match.
